led_pattern_scorer: RTL
=======================

# led_pattern_scorer

Reads the 8-bit light pattern driven by the light pattern generator, together with the synchronized Play press and the divided-clock tick, and judges the player. A press while the target LED is lit scores a hit; an early or missed press costs a life. Holds the score, miss count, best reaction time and game phase for the display and top-level logic. Sits beside the pattern generator in the top level, on the same Clk.

## Interface
Parameters:
- TARGET_BIT, 7: index of the pattern bit the player must hit.
- WIN_SCORE, 9: hits needed to win (1..15).
- MAX_MISS, 3: misses that end the game (1..3).

Ports:
- Clk  in  1  system clock; sole clock.
- Rst  in  1  reset; asynchronous, active-low.
- Tick  in  1  one-Clk enable pulse from the clock divider, one per pattern step.
- Begin  in  1  level; starts or restarts a game.
- Press  in  1  one-Clk pulse from the Play button synchronizer.
- Pattern  in  8  current LED pattern.
- Score  out  4  hits this game.
- Misses  out  2  misses this game.
- BestTime  out  4  fewest Ticks from target-lit to hit (15 = none yet).
- Hit  out  1  one-Clk pulse on a scored hit.
- Miss  out  1  one-Clk pulse on a miss.
- Phase  out  2  0 IDLE, 1 PLAY, 2 WIN, 3 LOSE.

## Operation
- lit = Pattern[TARGET_BIT]. lit_q is lit registered every Clk. rise = lit & ~lit_q. fall = ~lit & lit_q.
- IDLE: ignore Press. When Begin = 1: clear Score, Misses and lock; keep BestTime; go to PLAY.
- PLAY, per Clk, in priority order:
  - Press & (lit | fall) & ~lock → hit. Score+1, set lock, Hit pulse, reaction candidate = rtime.
  - Press & ~lit & ~fall, or Press & lock → early miss.
  - fall & ~lock & ~Press → late miss.
  - Each miss: Misses+1, Miss pulse.
  - rise clears lock and rtime.
  - While lit and not locked, rtime increments on Tick and saturates at 15.
- On a hit, BestTime = min(BestTime, rtime).
- Transitions out of PLAY:
  - The Score increment that reaches WIN_SCORE goes to WIN.
  - The Misses increment that reaches MAX_MISS goes to LOSE.
  - Both on the same Clk cannot happen, because hit and miss are mutually exclusive.
- WIN/LOSE: counters frozen. Begin → PLAY, with the same clearing as from IDLE.
- Begin held high during PLAY has no effect.
- Score and Misses never wrap; they stop at their terminal values.
- Rst low: all state is cleared immediately, including BestTime. This applies in any phase, including mid-game.

## Timing
- All outputs are registered. Hit, Miss, Score, Misses, BestTime and Phase update on the Clk edge that samples the triggering Press, fall or Begin. Latency is one edge.
- Reset values:
  - Phase = 0, Score = 0, Misses = 0, BestTime = 15.
  - Hit = 0, Miss = 0.
  - lit_q = 0, lock = 0, rtime = 0.
- A press on the fall cycle scores as a hit. This gives a one-Clk grace window.
- If Tick and Press arrive on the same Clk, rtime is taken before that Tick's increment.
- Hit and Miss are never both high. Each is at most one Clk wide per event.

## Structure
- Shared package holds:
  - Phase encodings: IDLE, PLAY, WIN, LOSE.
  - RTIME_MAX = 15.
- One sub-module, lit_edge_detect. It registers lit and produces rise and fall. All other logic lives in the scorer.

## Test plan
- Reset, then Begin. Set Pattern = 8'h80 for 5 Ticks and press after 2 Ticks → Hit pulse, Score = 1, BestTime = 2, Misses = 0.
- In PLAY, press with Pattern = 8'h01 → Miss pulse, Misses = 1, Score unchanged.
- Pattern 8'h80 → 8'h40 with no press → Miss pulse on the fall edge, Misses = 1. A second press in the same lit interval also → Miss.
- Score 9 hits → Phase = 2. Further presses are ignored. Begin → Phase = 1, Score = 0, BestTime kept.
- 3 misses → Phase = 3. Drive Rst low mid-PLAY → Phase = 0, Score = 0, Misses = 0, BestTime = 15, asynchronously.
- Press on the exact fall cycle (Pattern leaves 8'h80) → Hit pulse, not Miss.

Source files
------------

// File: rtl/led_pattern_scorer_pkg.sv
// Shared definitions for the LED reaction game scorer: phase encodings
// and the reaction-time ceiling.
package led_pattern_scorer_pkg;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_PLAY = 2'd1,
    PH_WIN  = 2'd2,
    PH_LOSE = 2'd3
  } phase_e;

  localparam logic [3:0] RTIME_MAX = 4'd15;

  function automatic logic [3:0] min4(input logic [3:0] a, input logic [3:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/led_pattern_scorer_lit_edge_detect.sv
// Registers the target-LED level and reports its rising and falling edges
// relative to the previous Clk.
module lit_edge_detect (
  input  logic Clk,
  input  logic Rst,
  input  logic lit_i,
  output logic rise_o,
  output logic fall_o
);

  logic lit_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) lit_q <= 1'b0;
    else      lit_q <= lit_i;
  end

  assign rise_o = lit_i & ~lit_q;
  assign fall_o = ~lit_i & lit_q;

endmodule

// File: rtl/led_pattern_scorer.sv
// Judges Play presses against the target LED: counts hits and misses,
// tracks the best reaction time and runs the IDLE/PLAY/WIN/LOSE phases.
module led_pattern_scorer
  import led_pattern_scorer_pkg::*;
#(
  parameter int TARGET_BIT = 7,
  parameter int WIN_SCORE  = 9,
  parameter int MAX_MISS   = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tick,
  input  logic       Begin,
  input  logic       Press,
  input  logic [7:0] Pattern,
  output logic [3:0] Score,
  output logic [1:0] Misses,
  output logic [3:0] BestTime,
  output logic       Hit,
  output logic       Miss,
  output logic [1:0] Phase
);

  localparam logic [7:0] TARGET_MASK = 8'b1 << TARGET_BIT;
  localparam logic [3:0] WIN_L       = 4'(WIN_SCORE);
  localparam logic [1:0] MISS_L      = 2'(MAX_MISS);

  logic   lit, rise, fall;
  phase_e phase_q, phase_d;
  logic [3:0] score_q, score_d, best_q, best_d, rtime_q, rtime_d, rtime_eff;
  logic [1:0] misses_q, misses_d;
  logic       hit_q, hit_d, miss_q, miss_d, lock_q, lock_d, lock_eff;
  logic       in_play, hit_ev, early_ev, late_ev;

  assign lit = |(Pattern & TARGET_MASK);

  lit_edge_detect u_edge (
    .Clk    (Clk),
    .Rst    (Rst),
    .lit_i  (lit),
    .rise_o (rise),
    .fall_o (fall)
  );

  // A new lit interval starts unlocked with a fresh timer, even on its first Clk.
  assign lock_eff  = lock_q & ~rise;
  assign rtime_eff = rise ? 4'd0 : rtime_q;

  assign in_play  = (phase_q == PH_PLAY);
  assign hit_ev   = in_play & Press & (lit | fall) & ~lock_eff;
  assign early_ev = in_play & Press & ~hit_ev;
  assign late_ev  = in_play & fall & ~lock_eff & ~Press;

  always_comb begin
    phase_d  = phase_q;
    score_d  = score_q;
    misses_d = misses_q;
    best_d   = best_q;
    lock_d   = lock_q;
    rtime_d  = rtime_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;

    if (rise) begin
      lock_d  = 1'b0;
      rtime_d = 4'd0;
    end else if (lit && !lock_q && Tick && rtime_q != RTIME_MAX) begin
      rtime_d = rtime_q + 4'd1;
    end

    if (!in_play) begin
      if (Begin) begin
        score_d  = 4'd0;
        misses_d = 2'd0;
        lock_d   = 1'b0;
        phase_d  = PH_PLAY;
      end
    end else if (hit_ev) begin
      hit_d  = 1'b1;
      lock_d = 1'b1;
      best_d = min4(best_q, rtime_eff);
      if (score_q != 4'hF) score_d = score_q + 4'd1;
      if (score_q + 4'd1 == WIN_L) phase_d = PH_WIN;
    end else if (early_ev || late_ev) begin
      miss_d = 1'b1;
      if (misses_q != 2'd3) misses_d = misses_q + 2'd1;
      if (misses_q + 2'd1 == MISS_L) phase_d = PH_LOSE;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      phase_q  <= PH_IDLE;
      score_q  <= 4'd0;
      misses_q <= 2'd0;
      best_q   <= RTIME_MAX;
      lock_q   <= 1'b0;
      rtime_q  <= 4'd0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      best_q   <= best_d;
      lock_q   <= lock_d;
      rtime_q  <= rtime_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign Score    = score_q;
  assign Misses   = misses_q;
  assign BestTime = best_q;
  assign Hit      = hit_q;
  assign Miss     = miss_q;
  assign Phase    = phase_q;

endmodule
